mips32_prog_loader: RTL and testbench
=====================================

// Module: mips32_prog_loader
// PURPOSE
//   Boot-time program loader in front of the pipelined MIPS32 core. Zeroes instruction/data memory,
//   streams program words from a valid/ready source into memory from address 0, then releases the
//   core from reset and waits for its HALTED flag. Replaces hierarchical memory pokes in benches
//   and gives a synthesizable boot path.
// PARAMETERS
//   ADDR_W      10      memory word-address width (2**ADDR_W words cleared and loadable)
//   DATA_W      32      instruction/data word width
//   HLT_OPCODE  6'h3f   opcode in [31:26] identifying HLT (sets hlt_seen)
// PORTS
//   clk1        in   1       single clock; whole block is in this domain
//   rst_n       in   1       asynchronous, active-low reset
//   start       in   1       1-cycle pulse: begin clear+load; honoured only in IDLE or DONE
//   in_valid    in   1       program word valid
//   in_data     in   DATA_W  program word
//   in_last     in   1       marks final word of the stream (qualified by in_valid)
//   in_ready    out  1       loader accepts word this cycle
//   mem_we      out  1       memory write strobe (registered)
//   mem_addr    out  ADDR_W  memory word address (registered)
//   mem_wdata   out  DATA_W  memory write data (registered)
//   core_halted in   1       core HALTED flag (two-phase-clocked core: synchronised here)
//   core_rst_n  out  1       core reset, low holds core (PC=0, pipeline regs cleared)
//   busy        out  1       high in CLEAR/LOAD/RELEASE/RUN
//   done        out  1       high in DONE
//   err         out  2       [0] overflow, [1] checksum mismatch; sticky until next start
//   hlt_seen    out  1       an HLT_OPCODE word was written during LOAD
//   word_count  out  ADDR_W+1 number of program words written
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 (core_rst_n=0, in_ready=0); async assert deasserts core at once.
//   FSM IDLE -start-> CLEAR -last addr-> LOAD -in_last accepted-> RELEASE -> RUN -halted-> DONE.
//   IDLE/DONE: start clears err, hlt_seen, word_count, enters CLEAR; start elsewhere ignored.
//   CLEAR: one write/cycle, addr 0..2**ADDR_W-1, wdata 0 (1024 cycles default); in_ready=0.
//   LOAD: in_ready=1; accept = in_valid&in_ready; write issued cycle after accept at addr=wptr;
//     wptr, word_count increment per written word; in_ready=0 one cycle after in_last accepted.
//   Overflow: accept while wptr==2**ADDR_W -> err[0]=1, word dropped, go DONE, core_rst_n stays 0.
//   RELEASE: one cycle after last mem_we; core_rst_n rises entering RUN.
//   RUN: core_halted via 2-flop sync; synced high -> DONE (done=1, busy=0, core_rst_n held 1).
//   in_valid outside LOAD ignored (no write, no count). mem_we never asserted in IDLE/RUN/DONE.
//   Any error path ends in DONE with core_rst_n=0; done still asserts.
//   rst_n low mid-operation: FSM to IDLE, partial memory contents undefined; reload required.
// CONFIGURATION
//   MIPS32_LOADER_CHECKSUM_EN defined: in_last word is a checksum, not written; compared to
//     mod-2**32 sum of written words; mismatch -> err[1]=1, DONE, core never released.
//   Not defined: in_last word is an ordinary program word, written and counted; err[1] tied 0.
// STRUCTURE
//   Package mips32_loader_pkg: state enum (IDLE,CLEAR,LOAD,RELEASE,RUN,DONE), HLT_OPCODE default,
//     err bit indices ERR_OVF=0, ERR_CSUM=1.
//   Sub-module mips32_sync2: 2-flop synchroniser for core_halted, reset value 0.
// TESTING
//   1 Reset then start: 1024 writes of 0 addr 0..1023, busy=1, in_ready=0 throughout CLEAR.
//   2 Stream 2801000a,28020014,28030019,0ce77800,0ce77800,00222000,0ce77800,0ce77800,00832800,
//     fc000000(last) -> Mem[0..9] match, word_count=10, hlt_seen=1, core_rst_n rises; core R4=30,
//     R5=55; core_halted -> done=1 within 3 cycles.
//   3 Same stream, in_valid toggled every other cycle -> identical memory, count 10.
//   4 Stream 1025 words, none last -> err=01, 1024 words written, done=1, core_rst_n=0.
//   5 CHECKSUM_EN: 3 words 1,2,3 then last=6 -> err=00, count 3, released; last=7 -> err=10, held.
//   6 rst_n low during LOAD word 5 -> all outputs 0 at once; start after reset redoes CLEAR+LOAD.

Source files
------------

// File: rtl/mips32_loader_pkg.sv
// ---------------------------------------------------------------------------
// mips32_loader_pkg
//   Shared definitions for the MIPS32 boot-time program loader:
//     - loader_state_e : loader FSM states
//     - HLT_OPCODE_DEF : default opcode field value of the HLT instruction
//     - ERR_OVF/ERR_CSUM : bit positions inside the err status vector
//     - is_hlt()       : opcode-field compare used when tracking hlt_seen
// ---------------------------------------------------------------------------
package mips32_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4,
    DONE    = 3'd5
  } loader_state_e;

  localparam logic [5:0] HLT_OPCODE_DEF = 6'h3f;

  localparam int ERR_OVF  = 0;
  localparam int ERR_CSUM = 1;

  // True when the opcode field (instruction bits [31:26]) equals the HLT opcode.
  function automatic logic is_hlt(input logic [5:0] op_field, input logic [5:0] hlt_op);
    return op_field == hlt_op;
  endfunction

endpackage

// File: rtl/mips32_prog_loader_if.sv
// ---------------------------------------------------------------------------
// mips32_prog_loader_if
//   Bundles the loader's two bus-style connections:
//     program stream : in_valid, in_data, in_last (source -> loader), in_ready (loader -> source)
//     memory write   : mem_we, mem_addr, mem_wdata (loader -> instruction/data memory)
//   Modports:
//     slave  : the loader side (consumes the stream, drives the memory bus)
//     master : the environment side (program source and memory)
// ---------------------------------------------------------------------------
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_sync2.sv
// ---------------------------------------------------------------------------
// mips32_sync2
//   Two-flop synchroniser for a single level signal (used for the core's
//   HALTED flag, which comes from the two-phase-clocked core).
//   Ports:
//     clk   in  destination clock
//     rst_n in  asynchronous active-low reset, output resets to 0
//     d     in  asynchronous level input
//     q     out synchronised level (two clk edges of latency)
// ---------------------------------------------------------------------------
module mips32_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/mips32_prog_loader.sv
// ---------------------------------------------------------------------------
// mips32_prog_loader
//   Boot path for the pipelined MIPS32 core: on start it zeroes all
//   2**ADDR_W memory words, streams program words from a valid/ready source
//   into memory from address 0, releases the core from reset and waits for
//   the core's HALTED flag.
//
//   Optional feature (compile-time macro MIPS32_LOADER_CHECKSUM_EN):
//     defined     : the in_last word is a checksum (not written, not counted)
//                   compared against the mod-2**DATA_W sum of the written
//                   words; a mismatch sets err[1] and the core stays in reset.
//     not defined : the in_last word is an ordinary program word; err[1] is 0.
//
//   Ports:
//     clk1        in   single clock
//     rst_n       in   asynchronous active-low reset
//     start       in   1-cycle pulse, honoured in IDLE or DONE only
//     bus         slave modport: program stream in, memory write bus out
//     core_halted in   core HALTED flag (synchronised internally)
//     core_rst_n  out  core reset, low holds the core
//     busy        out  high in CLEAR/LOAD/RELEASE/RUN
//     done        out  high in DONE
//     err         out  [0] overflow, [1] checksum mismatch; sticky until start
//     hlt_seen    out  an HLT word was written during LOAD
//     word_count  out  number of program words written
// ---------------------------------------------------------------------------
module mips32_prog_loader
  import mips32_loader_pkg::*;
#(
  parameter int         ADDR_W     = 10,
  parameter int         DATA_W     = 32,
  parameter logic [5:0] HLT_OPCODE = HLT_OPCODE_DEF
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                start,
  mips32_prog_loader_if.slave bus,
  input  logic                core_halted,
  output logic                core_rst_n,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err,
  output logic                hlt_seen,
  output logic [ADDR_W:0]     word_count
);

  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  loader_state_e     state_reg;
  logic              in_ready_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              core_rst_n_reg;
  logic [1:0]        err_reg;
  logic              hlt_reg;
  // Write pointer; every written word advances it, so it doubles as word_count.
  logic [ADDR_W:0]   wptr_reg;

  logic halted_sync;
  logic accept;
  logic full;
  logic csum_word;

  mips32_sync2 u_halt_sync (
    .clk   (clk1),
    .rst_n (rst_n),
    .d     (core_halted),
    .q     (halted_sync)
  );

  assign accept = bus.in_valid & in_ready_reg;
  assign full   = (wptr_reg == DEPTH);

`ifdef MIPS32_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg;
  assign csum_word = bus.in_last;
`else
  assign csum_word = 1'b0;
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      in_ready_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      core_rst_n_reg <= 1'b0;
      err_reg        <= '0;
      hlt_reg        <= 1'b0;
      wptr_reg       <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
      sum_reg        <= '0;
`endif
    end else begin
      // The write strobe is a single-cycle pulse unless a branch below renews it.
      mem_we_reg <= 1'b0;

      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg      <= CLEAR;
            err_reg        <= '0;
            hlt_reg        <= 1'b0;
            wptr_reg       <= '0;
            core_rst_n_reg <= 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_reg        <= '0;
`endif
            // First clear write goes out in the first CLEAR cycle.
            mem_we_reg     <= 1'b1;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
          end
        end

        CLEAR: begin
          if (mem_addr_reg == LAST_ADDR) begin
            state_reg    <= LOAD;
            in_ready_reg <= 1'b1;
          end else begin
            mem_we_reg   <= 1'b1;
            mem_addr_reg <= mem_addr_reg + 1'b1;
          end
        end

        LOAD: begin
          if (accept) begin
            if (csum_word) begin
              // Checksum word is never written, so it is exempt from the
              // overflow test and a full 2**ADDR_W-word program still fits.
              in_ready_reg <= 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
              if (bus.in_data == sum_reg) begin
                state_reg <= RELEASE;
              end else begin
                err_reg[ERR_CSUM] <= 1'b1;
                state_reg         <= DONE;
              end
`endif
            end else if (full) begin
              in_ready_reg     <= 1'b0;
              err_reg[ERR_OVF] <= 1'b1;
              state_reg        <= DONE;
            end else begin
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= wptr_reg[ADDR_W-1:0];
              mem_wdata_reg <= bus.in_data;
              wptr_reg      <= wptr_reg + 1'b1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
              sum_reg       <= sum_reg + bus.in_data;
`endif
              if (is_hlt(bus.in_data[31:26], HLT_OPCODE)) begin
                hlt_reg <= 1'b1;
              end
              if (bus.in_last) begin
                in_ready_reg <= 1'b0;
                state_reg    <= RELEASE;
              end
            end
          end
        end

        // The final program write (if any) is on the bus during this cycle;
        // the core leaves reset only once it has completed.
        RELEASE: begin
          state_reg      <= RUN;
          core_rst_n_reg <= 1'b1;
        end

        RUN: begin
          if (halted_sync) begin
            state_reg <= DONE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  assign core_rst_n = core_rst_n_reg;
  assign busy       = (state_reg == CLEAR) || (state_reg == LOAD) ||
                      (state_reg == RELEASE) || (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign err        = err_reg;
  assign hlt_seen   = hlt_reg;
  assign word_count = wptr_reg;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_mips32_prog_loader
//   Scoreboarded bench for mips32_prog_loader. Expected memory writes are
//   queued when a start or a program stream is issued; a monitor pops and
//   compares every mem_we cycle. Final status (err, word_count, hlt_seen,
//   core release, done) comes from a small reference model of the loading
//   rules. Honours MIPS32_LOADER_CHECKSUM_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mips32_prog_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef MIPS32_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic          rst_n;
  logic          start;
  logic          core_halted;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic          hlt_seen;
  logic [AW:0]   word_count;

  mips32_prog_loader_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

  mips32_prog_loader #(
    .ADDR_W     (AW),
    .DATA_W     (32),
    .HLT_OPCODE (6'h3f)
  ) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .core_halted (core_halted),
    .core_rst_n  (core_rst_n),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .hlt_seen    (hlt_seen),
    .word_count  (word_count)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          clr;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors     = 0;
  int  miscompares = 0;
  bit  toggle      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, {core_rst_n, busy, done, err, hlt_seen, word_count,
                 bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'd0);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk1) begin
    if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 64'hffff_ffff_ffff_ffff);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, mon_e.addr);
        check("wr_data", bus.mem_wdata, mon_e.data);
        check("wr_core_held", core_rst_n, 0);
        if (mon_e.clr) check("clear_busy_noready", {busy, bus.in_ready}, 2'b10);
        $display("write addr=%0d data=%08h %s", bus.mem_addr, bus.mem_wdata,
                 mon_e.clr ? "clear" : "load");
      end
    end
  end

  task automatic do_start(input bit garbage);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back('{a, 32'h0, 1'b1});
    @(negedge clk1); start = 1'b1;
    @(negedge clk1); start = 1'b0;
    check("start_clears", {busy, done, err, hlt_seen, word_count}, {1'b1, 15'd0});
    for (int cyc = 0; cyc < DEPTH + 16; cyc++) begin
      @(negedge clk1);
      if (bus.in_ready === 1'b1) break;
      if (garbage) begin
        bus.in_valid = 1'($urandom_range(1));
        bus.in_data  = $urandom;
        bus.in_last  = 1'($urandom_range(1));
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("clear_reaches_load", bus.in_ready, 1);
    check("clear_writes_drained", exp_q.size(), 0);
  endtask

  task automatic send_words(input logic [31:0] w[$], input bit has_last, input int mode,
                            input bit poke_start);
    for (int i = 0; i < w.size(); i++) begin
      bit acc;
      bit want;
      int cyc;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 64) begin
        @(negedge clk1);
        want   = (mode == 0) ? 1'b1 : (mode == 1) ? toggle : ($urandom_range(99) >= 40);
        toggle = ~toggle;
        bus.in_valid = want;
        bus.in_data  = want ? w[i] : $urandom;
        bus.in_last  = want ? (has_last && i == w.size() - 1) : 1'($urandom_range(1));
        start        = poke_start && i == 2 && cyc == 0;
        acc          = want && (bus.in_ready === 1'b1);
        cyc++;
      end
      check("word_accepted", acc, 1);
      if (!acc) break;
    end
    @(negedge clk1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    start        = 1'b0;
  endtask

  task automatic halt_phase();
    int lat;
    repeat ($urandom_range(1, 5)) begin
      @(negedge clk1);
      bus.in_valid = 1'($urandom_range(1));
      bus.in_data  = $urandom;
    end
    check("run_not_done", done, 0);
    core_halted = 1'b1;
    lat = 0;
    while (done !== 1'b1 && lat < 6) begin
      @(negedge clk1);
      lat++;
    end
    bus.in_valid = 1'b0;
    check("halt_to_done_le3", lat <= 3, 1);
    check("done_busy_core", {done, busy, core_rst_n}, 3'b101);
    core_halted = 1'b0;
  endtask

  // Reference model: which words get written, and the resulting status.
  task automatic run_load(input logic [31:0] w[$], input bit has_last, input int mode,
                          input bit poke_start);
    int          n_data;
    int          nw;
    logic [31:0] sum;
    bit          ovf, bad, rel, hlt;
    n_data = (CSUM && has_last) ? w.size() - 1 : w.size();
    ovf    = n_data > DEPTH;
    nw     = ovf ? DEPTH : n_data;
    sum    = 32'h0;
    hlt    = 1'b0;
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back('{i, w[i], 1'b0});
      sum = sum + w[i];
      if (w[i][31:26] == 6'h3f) hlt = 1'b1;
    end
    bad = CSUM && has_last && !ovf && (w[w.size() - 1] != sum);
    rel = has_last && !ovf && !bad;

    send_words(w, has_last, mode, poke_start);
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (core_rst_n === 1'b1 || done === 1'b1) break;
      @(negedge clk1);
    end
    check("core_released", core_rst_n, rel);
    check("done_flag", done, !rel);
    check("busy_flag", busy, rel);
    check("err", err, {bad, ovf});
    check("word_count", word_count, nw);
    check("hlt_seen", hlt_seen, hlt);
    check("load_writes_drained", exp_q.size(), 0);
    $display("load words=%0d last=%0d mode=%0d: count=%0d err=%b hlt=%0d released=%0d",
             w.size(), has_last, mode, word_count, err, hlt_seen, core_rst_n);
    if (rel) begin
      halt_phase();
    end else begin
      repeat (4) @(negedge clk1);
      check("core_stays_held", {core_rst_n, done}, 2'b01);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[$];
    logic [31:0] part[$];
    logic [31:0] big[$];
    logic [31:0] rnd[$];
    logic [31:0] s;

    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h0ce77800, 32'h00832800, 32'hfc000000};

    rst_n        = 1'b0;
    start        = 1'b0;
    core_halted  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk1);
    check_reset("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk1);
    check_reset("idle_outputs");

    // Reference program, continuous valid, garbage on the stream during CLEAR.
    do_start(1'b1);
    run_load(prog, 1'b1, 0, 1'b0);

    // Same program with in_valid toggled every other cycle and a stray start in LOAD.
    do_start(1'b0);
    run_load(prog, 1'b1, 1, 1'b1);

    // Overflow: 2**AW + 1 words and no last marker.
    big = {};
    for (int i = 0; i < DEPTH + 1; i++) big.push_back($urandom);
    do_start(1'b0);
    run_load(big, 1'b0, 0, 1'b0);

`ifdef MIPS32_LOADER_CHECKSUM_EN
    do_start(1'b0);
    run_load('{32'd1, 32'd2, 32'd3, 32'd6}, 1'b1, 0, 1'b0);
    do_start(1'b0);
    run_load('{32'd1, 32'd2, 32'd3, 32'd7}, 1'b1, 0, 1'b0);
`endif

    // Asynchronous reset while LOAD is in progress, then a full reload.
    do_start(1'b0);
    part = prog[0:4];
    for (int i = 0; i < 5; i++) exp_q.push_back('{i, part[i], 1'b0});
    send_words(part, 1'b0, 0, 1'b0);
    @(negedge clk1);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset_mid_load");
    check("reset_pending_writes", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk1);
    rst_n = 1'b1;
    do_start(1'b1);
    run_load(prog, 1'b1, 2, 1'b0);

    // Randomised programs with random valid gaps.
    for (int r = 0; r < 3; r++) begin
      rnd = {};
      s   = 32'h0;
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
        logic [31:0] wd;
        wd = $urandom;
        if ($urandom_range(99) < 20) wd[31:26] = 6'h3f;
        rnd.push_back(wd);
        s = s + wd;
      end
      if (CSUM) rnd.push_back(($urandom_range(1) != 0) ? s : s + 32'd1);
      do_start(1'($urandom_range(1)));
      run_load(rnd, 1'b1, 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
